// File: rtl/urv_mult_pkg.sv
// ---------------------------------------------------------------------------
// urv_mult_pkg
// Shared constants and types for the uRV pipelined multiply unit:
//   - RISC-V funct3 encodings handled by the unit
//   - limb width of the partial-product decomposition
//   - per-stage control payload carried alongside the datapath
// ---------------------------------------------------------------------------
package urv_mult_pkg;

    localparam logic [2:0] MUL_FUN_MUL    = 3'b000;
    localparam logic [2:0] MUL_FUN_MULH   = 3'b001;
    localparam logic [2:0] MUL_FUN_MULHSU = 3'b010;
    localparam logic [2:0] MUL_FUN_MULHU  = 3'b011;

    // Unsigned limb width; the signed multiplier primitive is one bit wider.
    localparam int unsigned MUL_LIMB_W    = 17;

    // Widest tag a stage can carry; the top level uses the low TAG_W bits.
    localparam int unsigned MUL_TAG_MAX_W = 16;

    typedef struct packed {
        logic                     valid;
        logic [MUL_TAG_MAX_W-1:0] tag;
        logic [2:0]               fun;
    } mul_stage_t;

endpackage

// File: rtl/urv_mult_limb.sv
// ---------------------------------------------------------------------------
// urv_mult_limb
// Registered 18x18 signed multiply with clock enable. One instance per limb
// pair; swap the body for a platform DSP primitive where one is available.
// Ports:
//   clk_i, rst_n_i  clock, async active-low reset (product register -> 0)
//   en_i            load enable; product register holds when low
//   a_i, b_i        signed 18-bit limb operands
//   p_o             registered signed 36-bit product
// ---------------------------------------------------------------------------
module urv_mult_limb
    import urv_mult_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           en_i,
    input  logic signed [MUL_LIMB_W:0]     a_i,
    input  logic signed [MUL_LIMB_W:0]     b_i,
    output logic signed [2*MUL_LIMB_W+1:0] p_o
);

    localparam int unsigned PROD_W = 2 * (MUL_LIMB_W + 1);

    logic signed [PROD_W-1:0] p_d;
    logic signed [PROD_W-1:0] p_q;

    // Operands widened to the product width so the multiply keeps all bits.
    always_comb begin
        p_d = p_q;
        if (en_i) begin
            p_d = PROD_W'(a_i) * PROD_W'(b_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/urv_mult_pipe.sv
// ---------------------------------------------------------------------------
// urv_mult_pipe
// Pipelined RV32M/RV64M multiply unit (MUL, MULH, MULHSU, MULHU) with
// valid/ready handshake on both sides, flush and a pass-through tag.
// Build option: define URV_MULH_EN to build the full 2*XLEN product and
// support the high-half functions; otherwise only the low half is built and
// MULH/MULHSU/MULHU return 0.
// Parameters: XLEN (32/64), LATENCY (1..4), TAG_W (<= 16)
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   flush_i          kills every in-flight operation at the next edge
//   valid_i/ready_o  input handshake; ready_o is combinational from ready_i
//   rs1_i, rs2_i     operands; fun_i funct3; tag_i opaque tag
//   valid_o/ready_i  output handshake
//   rd_o, tag_o      result and its tag
// ---------------------------------------------------------------------------
module urv_mult_pipe
    import urv_mult_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [2:0]       fun_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  rd_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int unsigned LW = MUL_LIMB_W;
    // Limbs needed to cover the XLEN+1-bit extended operand.
    localparam int unsigned NL = (XLEN + LW) / LW;
    localparam int unsigned EW = NL * LW;
`ifdef URV_MULH_EN
    localparam bit          HI_EN = 1'b1;
`else
    localparam bit          HI_EN = 1'b0;
`endif
    localparam int unsigned PW  = HI_EN ? 2 * XLEN : XLEN;
    localparam int unsigned RDN = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic                 adv;
    logic                 sx1;
    logic                 sx2;
    logic [EW-1:0]        a_ext;
    logic [EW-1:0]        b_ext;
    logic signed [LW:0]   a_l [NL];
    logic signed [LW:0]   b_l [NL];
    logic signed [2*LW+1:0] pp [NL][NL];
    logic [PW-1:0]        prod;
    logic [XLEN-1:0]      res;
    mul_stage_t           st_d [LATENCY];
    mul_stage_t           st_q [LATENCY];
    logic [XLEN-1:0]      rd_d [RDN];
    logic [XLEN-1:0]      rd_q [RDN];

    // Single global advance: the whole pipe moves or holds together.
    assign valid_o = st_q[LATENCY-1].valid;
    assign adv     = !valid_o || ready_i;
    assign ready_o = adv;
    assign tag_o   = st_q[LATENCY-1].tag[TAG_W-1:0];
    assign rd_o    = (LATENCY == 1) ? res : rd_q[RDN-1];

    // Extend operands per function and split into limbs; only the top limb
    // carries a sign, the lower ones are zero-extended to the signed primitive.
    always_comb begin
        sx1   = (fun_i == MUL_FUN_MULH) || (fun_i == MUL_FUN_MULHSU);
        sx2   = (fun_i == MUL_FUN_MULH);
        a_ext = {{(EW-XLEN){sx1 & rs1_i[XLEN-1]}}, rs1_i};
        b_ext = {{(EW-XLEN){sx2 & rs2_i[XLEN-1]}}, rs2_i};
        for (int i = 0; i < NL; i++) begin
            a_l[i] = {1'b0, a_ext[i*LW +: LW]};
            b_l[i] = {1'b0, b_ext[i*LW +: LW]};
        end
        a_l[NL-1] = {a_ext[EW-1], a_ext[EW-LW +: LW]};
        b_l[NL-1] = {b_ext[EW-1], b_ext[EW-LW +: LW]};
    end

    // Stage-1 limb products; pairs that only feed the upper half are skipped
    // when the high-half functions are not built.
    for (genvar i = 0; i < NL; i++) begin : g_a
        for (genvar j = 0; j < NL; j++) begin : g_b
            if (HI_EN || (LW * (i + j) < XLEN)) begin : g_pp
                urv_mult_limb u_limb (
                    .clk_i   (clk_i),
                    .rst_n_i (rst_n_i),
                    .en_i    (adv),
                    .a_i     (a_l[i]),
                    .b_i     (b_l[j]),
                    .p_o     (pp[i][j])
                );
            end else begin : g_nopp
                assign pp[i][j] = '0;
            end
        end
    end

    // Column sum of the registered limb products, modulo 2^PW.
    always_comb begin
        prod = '0;
        for (int i = 0; i < NL; i++) begin
            for (int j = 0; j < NL; j++) begin
                prod = prod + (PW'(pp[i][j]) << (LW * (i + j)));
            end
        end
    end

    // Result half selection; divide encodings (fun[2]=1) fall to default.
    always_comb begin
        res = '0;
        case (st_q[0].fun)
            MUL_FUN_MUL: res = prod[XLEN-1:0];
            MUL_FUN_MULH, MUL_FUN_MULHSU, MUL_FUN_MULHU: begin
`ifdef URV_MULH_EN
                res = prod[PW-1:XLEN];
`else
                res = '0;
`endif
            end
            default: res = '0;
        endcase
    end

    // Stage shift on advance; flush clears every valid bit and wins over both.
    always_comb begin
        st_d = st_q;
        rd_d = rd_q;
        if (adv) begin
            st_d[0] = '{valid: valid_i, tag: MUL_TAG_MAX_W'(tag_i), fun: fun_i};
            for (int k = 1; k < LATENCY; k++) begin
                st_d[k] = st_q[k-1];
            end
            rd_d[0] = res;
            for (int k = 1; k < RDN; k++) begin
                rd_d[k] = rd_q[k-1];
            end
        end
        if (flush_i) begin
            for (int k = 0; k < LATENCY; k++) begin
                st_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < LATENCY; k++) begin
                st_q[k] <= '0;
            end
            for (int k = 0; k < RDN; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            st_q <= st_d;
            rd_q <= rd_d;
        end
    end

endmodule
